// File: rtl/ws2811_receiver_if.sv
// ws2811_receiver_if: decoded pixel/frame event bundle from the WS2811 receiver.
// master drives the events, slave consumes them.
interface ws2811_receiver_if;
    logic [23:0] pixelOUT;
    logic [15:0] indexOUT;
    logic        validOUT;
    logic        latchOUT;
    logic        errorOUT;

    modport master (
        output pixelOUT,
        output indexOUT,
        output validOUT,
        output latchOUT,
        output errorOUT
    );

    modport slave (
        input pixelOUT,
        input indexOUT,
        input validOUT,
        input latchOUT,
        input errorOUT
    );
endinterface

// File: rtl/ws2811_receiver.sv
// ws2811_receiver: WS2811/WS2812 serial line to 24-bit pixel words.
// Optional WS2811_RX_GLITCH_FILTER_EN adds a 3-sample majority filter.
module ws2811_receiver #(
    parameter int CLOCK_SPEED  = 50_000_000,
    parameter int THRESHOLD_NS = 500,
    parameter int MAX_HIGH_NS  = 2000,
    parameter int RESET_NS     = 50_000
) (
    input  logic              clkIN,
    input  logic              resetIN,
    input  logic              dataIN,
    ws2811_receiver_if.master rx
);

    localparam longint CLK_KHZ = longint'(CLOCK_SPEED / 1000);
    localparam int THRESHOLD_CYCLES =
        int'(CLK_KHZ * THRESHOLD_NS / 1_000_000);
    localparam int MAX_HIGH_CYCLES =
        int'(CLK_KHZ * MAX_HIGH_NS / 1_000_000);
    localparam int RESET_CYCLES =
        int'(CLK_KHZ * RESET_NS / 1_000_000);
    localparam int CW = $clog2(RESET_CYCLES + 1);

    localparam logic [CW-1:0] THR      = CW'(THRESHOLD_CYCLES);
    localparam logic [CW-1:0] MAX_LAST = CW'(MAX_HIGH_CYCLES - 1);
    localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        WAIT_RESET,
        IDLE,
        HIGH,
        LOW
    } state_t;

    logic meta_q;
    logic sync_q;
    logic s;
    logic s_prev_q;

    always_ff @(posedge clkIN or posedge resetIN) begin
        if (resetIN) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= dataIN;
            sync_q <= meta_q;
        end
    end

`ifdef WS2811_RX_GLITCH_FILTER_EN
    logic d1_q;
    logic d2_q;
    logic filt_q;

    always_ff @(posedge clkIN or posedge resetIN) begin
        if (resetIN) begin
            d1_q   <= 1'b0;
            d2_q   <= 1'b0;
            filt_q <= 1'b0;
        end else begin
            d1_q   <= sync_q;
            d2_q   <= d1_q;
            filt_q <= (sync_q & d1_q) | (sync_q & d2_q) | (d1_q & d2_q);
        end
    end

    assign s = filt_q;
`else
    assign s = sync_q;
`endif

    state_t      state_q;
    logic [CW-1:0] cnt_q;
    logic [4:0]  bitcnt_q;
    logic [15:0] idx_q;
    logic [23:0] shift_q;
    logic [23:0] pixel_q;
    logic [15:0] index_q;
    logic        valid_q;
    logic        latch_q;
    logic        error_q;

    logic          rise;
    logic          fall;
    logic          bit_d;
    logic [23:0]   shift_d;
    logic [CW-1:0] cnt_d;

    assign rise    = s & ~s_prev_q;
    assign fall    = ~s & s_prev_q;
    assign bit_d   = (cnt_q >= THR);
    assign shift_d = {shift_q[22:0], bit_d};
    assign cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;

    always_ff @(posedge clkIN or posedge resetIN) begin
        if (resetIN) begin
            state_q  <= WAIT_RESET;
            s_prev_q <= 1'b0;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            pixel_q  <= '0;
            index_q  <= '0;
            valid_q  <= 1'b0;
            latch_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            s_prev_q <= s;
            valid_q  <= 1'b0;
            latch_q  <= 1'b0;
            error_q  <= 1'b0;
            unique case (state_q)
                // Only start decoding after a full gap: never mid-frame.
                WAIT_RESET: begin
                    if (s) begin
                        cnt_q <= '0;
                    end else if (cnt_q == RST_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                IDLE: begin
                    if (rise) begin
                        cnt_q   <= CNT_ONE;
                        state_q <= HIGH;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        shift_q <= shift_d;
                        cnt_q   <= CNT_ONE;
                        state_q <= LOW;
                        if (bitcnt_q == 5'd23) begin
                            pixel_q  <= shift_d;
                            index_q  <= idx_q;
                            valid_q  <= 1'b1;
                            idx_q    <= idx_q + 16'd1;
                            bitcnt_q <= '0;
                        end else begin
                            bitcnt_q <= bitcnt_q + 5'd1;
                        end
                    end else if (cnt_q == MAX_LAST) begin
                        error_q  <= 1'b1;
                        bitcnt_q <= '0;
                        idx_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= WAIT_RESET;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                LOW: begin
                    if (rise) begin
                        cnt_q   <= CNT_ONE;
                        state_q <= HIGH;
                    end else if (cnt_q == RST_LAST) begin
                        // A partial pixel at the latch gap is a framing error.
                        latch_q  <= 1'b1;
                        error_q  <= (bitcnt_q != 5'd0);
                        bitcnt_q <= '0;
                        idx_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
            endcase
        end
    end

    assign rx.pixelOUT = pixel_q;
    assign rx.indexOUT = index_q;
    assign rx.validOUT = valid_q;
    assign rx.latchOUT = latch_q;
    assign rx.errorOUT = error_q;

endmodule

// File: tb/tb_ws2811_receiver.sv
// tb_ws2811_receiver: directed frames against hand-computed pixels,
// indices and pulse latencies.
module tb_ws2811_receiver;

`ifdef WS2811_RX_GLITCH_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;
    int last_fall = 0;
    int rise_at = 0;

    typedef struct {
        int          cyc;
        logic [23:0] pix;
        logic [15:0] idx;
    } vev_t;

    vev_t vq[$];
    int   lq[$];
    int   eq[$];

    ws2811_receiver_if rx_if ();

    ws2811_receiver dut (
        .clkIN   (clk),
        .resetIN (rst),
        .dataIN  (din),
        .rx      (rx_if)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rx_if.validOUT)
            vq.push_back('{cyc, rx_if.pixelOUT, rx_if.indexOUT});
        if (rx_if.latchOUT) lq.push_back(cyc);
        if (rx_if.errorOUT) eq.push_back(cyc);
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] vpix(input int i);
        if (i < vq.size()) return 32'(vq[i].pix);
        return 'x;
    endfunction

    function automatic logic [31:0] vidx(input int i);
        if (i < vq.size()) return 32'(vq[i].idx);
        return 'x;
    endfunction

    function automatic int vcyc(input int i);
        if (i < vq.size()) return vq[i].cyc;
        return -100000;
    endfunction

    function automatic int lat_at(input int i);
        if (i < lq.size()) return lq[i];
        return -100000;
    endfunction

    function automatic int err_at(input int i);
        if (i < eq.size()) return eq[i];
        return -200000;
    endfunction

    task automatic clr();
        vq.delete();
        lq.delete();
        eq.delete();
    endtask

    task automatic idle(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        din = 1'b1;
        repeat (b ? 35 : 17) @(negedge clk);
        din = 1'b0;
        last_fall = cyc;
        repeat (b ? 27 : 45) @(negedge clk);
    endtask

    task automatic send_pix(input logic [23:0] p);
        for (int i = 23; i >= 0; i--) send_bit(p[i]);
    endtask

    initial begin
        logic [23:0] p;

        repeat (3) @(negedge clk);
        check("rst_pixel", 32'(rx_if.pixelOUT), 32'h0);
        check("rst_index", 32'(rx_if.indexOUT), 32'h0);
        check("rst_valid", 32'(rx_if.validOUT), 32'h0);
        check("rst_latch", 32'(rx_if.latchOUT), 32'h0);
        check("rst_error", 32'(rx_if.errorOUT), 32'h0);
        rst = 1'b0;

        // single pixel after the power-up gap
        idle(2600);
        clr();
        send_pix(24'hFF0080);
        check("p1_count", 32'(vq.size()), 32'd1);
        check("p1_pixel", vpix(0), 32'hFF0080);
        check("p1_index", vidx(0), 32'd0);
        check("p1_lat", 32'(vcyc(0) - last_fall), 32'(LAT));
        idle(3000);
        check("p1_latch", 32'(lq.size()), 32'd1);

        // three-pixel frame then latch
        clr();
        send_pix(24'h010203);
        send_pix(24'hA5A5A5);
        send_pix(24'h000000);
        idle(3000);
        check("f3_count", 32'(vq.size()), 32'd3);
        check("f3_pix0", vpix(0), 32'h010203);
        check("f3_pix1", vpix(1), 32'hA5A5A5);
        check("f3_pix2", vpix(2), 32'h000000);
        check("f3_idx0", vidx(0), 32'd0);
        check("f3_idx1", vidx(1), 32'd1);
        check("f3_idx2", vidx(2), 32'd2);
        check("f3_nlatch", 32'(lq.size()), 32'd1);
        check("f3_latlat", 32'(lat_at(0) - last_fall),
              32'(LAT + 2499));
        check("f3_nerr", 32'(eq.size()), 32'd0);
        clr();
        send_pix(24'h5A5A5A);
        idle(3000);
        check("f3_next_idx", vidx(0), 32'd0);
        check("f3_next_pix", vpix(0), 32'h5A5A5A);

        // partial pixel at the latch gap
        clr();
        p = 24'hAAAAAA;
        for (int i = 0; i < 10; i++) send_bit(p[i]);
        idle(3000);
        check("part_valid", 32'(vq.size()), 32'd0);
        check("part_latch", 32'(lq.size()), 32'd1);
        check("part_err", 32'(eq.size()), 32'd1);
        check("part_same", 32'(err_at(0) - lat_at(0)), 32'd0);

        // stuck-high line mid-frame
        clr();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        din = 1'b1;
        rise_at = cyc;
        repeat (150) @(negedge clk);
        din = 1'b0;
        repeat (40) @(negedge clk);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        idle(3000);
        send_pix(24'hC3C3C3);
        idle(3000);
        check("stuck_nerr", 32'(eq.size()), 32'd1);
        check("stuck_lat", 32'(err_at(0) - rise_at), 32'(LAT + 99));
        check("stuck_nvalid", 32'(vq.size()), 32'd1);
        check("stuck_pix", vpix(0), 32'hC3C3C3);
        check("stuck_idx", vidx(0), 32'd0);
        check("stuck_nlatch", 32'(lq.size()), 32'd1);

        // reset asserted mid-pixel
        clr();
        send_pix(24'h111111);
        send_pix(24'h222222);
        check("mid_pre_idx", 32'(rx_if.indexOUT), 32'd1);
        p = 24'hABCDEF;
        for (int i = 23; i >= 12; i--) send_bit(p[i]);
        rst = 1'b1;
        #1;
        check("mid_rst_pix", 32'(rx_if.pixelOUT), 32'h0);
        check("mid_rst_idx", 32'(rx_if.indexOUT), 32'h0);
        check("mid_rst_valid", 32'(rx_if.validOUT), 32'h0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        check("mid_no_extra", 32'(vq.size()), 32'd2);
        idle(2600);
        clr();
        send_pix(24'h123456);
        idle(3000);
        check("mid_pix", vpix(0), 32'h123456);
        check("mid_idx", vidx(0), 32'd0);
        check("mid_nerr", 32'(eq.size()), 32'd0);

        // one-cycle glitch inside the low phase of the first bit
        clr();
        p = 24'h00FF00;
        din = 1'b1;
        repeat (17) @(negedge clk);
        din = 1'b0;
        repeat (20) @(negedge clk);
        din = 1'b1;
        @(negedge clk);
        din = 1'b0;
        repeat (24) @(negedge clk);
        for (int i = 22; i >= 0; i--) send_bit(p[i]);
        idle(3000);
        check("gl_nvalid", 32'(vq.size()), 32'd1);
        check("gl_nlatch", 32'(lq.size()), 32'd1);
`ifdef WS2811_RX_GLITCH_FILTER_EN
        check("gl_pix", vpix(0), 32'h00FF00);
        check("gl_nerr", 32'(eq.size()), 32'd0);
`else
        check("gl_pix", vpix(0), 32'h007F80);
        check("gl_nerr", 32'(eq.size()), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
